// File: rtl/fp_addsub_pipe_if.sv
// Operand/result bundle for fp_addsub_pipe.
// master drives in_A/in_B/in_Sub/in_En; slave returns out_Out/out_Ready/out_Flags.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] in_A;
  logic [W-1:0] in_B;
  logic         in_Sub;
  logic         in_En;
  logic [W-1:0] out_Out;
  logic         out_Ready;
  logic [2:0]   out_Flags;

  modport master (
    output in_A, in_B, in_Sub, in_En,
    input  out_Out, out_Ready, out_Flags
  );

  modport slave (
    input  in_A, in_B, in_Sub, in_En,
    output out_Out, out_Ready, out_Flags
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Pipelined float add/sub, round-to-nearest-even, latency 4, 1 op/clk.
// Ports: clk, rst (async, active high), bus (slave: operands in, result+flags out).
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic            clk,
  input logic            rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SW    = MAN_W + 4;
  localparam int AW    = MAN_W + 5;
  localparam int SHMAX = MAN_W + 3;
  localparam int LZW   = $clog2(SW + 1);
  localparam int EW    = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

  localparam logic [EW-1:0] EMAXW = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
  } s0_t;

  typedef struct packed {
    logic             nan;
    logic             inf;
    logic             inf_s;
    logic             s_big;
    logic             s_sml;
    logic [EXP_W-1:0] e_big;
    logic [EXP_W-1:0] diff;
    logic [MAN_W:0]   m_big;
    logic [MAN_W:0]   m_sml;
  } s1_t;

  typedef struct packed {
    logic             nan;
    logic             inf;
    logic             inf_s;
    logic             sign;
    logic             zsign;
    logic [EXP_W-1:0] e;
    logic [AW-1:0]    sum;
  } s2_t;

  typedef struct packed {
    logic          nan;
    logic          inf;
    logic          inf_s;
    logic          sign;
    logic          zero;
    logic [EW-1:0] e;
    logic [SW-1:0] m;
  } s3_t;

  logic v0, v1, v2, v3;
  s0_t  r0;
  s1_t  r1, c1;
  s2_t  r2, c2;
  s3_t  r3, c3;

  // unpack / swap
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, ia, ib, na, nb;
  logic [W-2:0]     ka, kb;

  always_comb begin
    sa = r0.a[W-1];
    sb = r0.b[W-1] ^ r0.sub;
    ea = r0.a[W-2:MAN_W];
    eb = r0.b[W-2:MAN_W];
    fa = r0.a[MAN_W-1:0];
    fb = r0.b[MAN_W-1:0];
    za = (ea == '0);
    zb = (eb == '0);
    ia = (&ea) && (fa == '0);
    ib = (&eb) && (fb == '0);
    na = (&ea) && (fa != '0);
    nb = (&eb) && (fb != '0);
    // subnormals flush to zero magnitude
    ka = za ? '0 : r0.a[W-2:0];
    kb = zb ? '0 : r0.b[W-2:0];
    c1 = '0;
    c1.nan   = na | nb | (ia & ib & (sa ^ sb));
    c1.inf   = ia | ib;
    c1.inf_s = ia ? sa : sb;
    if (kb > ka) begin
      c1.s_big = sb;
      c1.s_sml = sa;
      c1.e_big = kb[W-2:MAN_W];
      c1.diff  = kb[W-2:MAN_W] - ka[W-2:MAN_W];
      c1.m_big = {~zb, kb[MAN_W-1:0]};
      c1.m_sml = {~za, ka[MAN_W-1:0]};
    end else begin
      c1.s_big = sa;
      c1.s_sml = sb;
      c1.e_big = ka[W-2:MAN_W];
      c1.diff  = ka[W-2:MAN_W] - kb[W-2:MAN_W];
      c1.m_big = {~za, ka[MAN_W-1:0]};
      c1.m_sml = {~zb, kb[MAN_W-1:0]};
    end
  end

  // align / add
  logic [EXP_W-1:0] sh;
  logic [2*SW-1:0]  wide;
  logic [SW-1:0]    aln;
  logic [AW-1:0]    xb, xs;

  always_comb begin
    sh = (r1.diff > EXP_W'(SHMAX)) ? EXP_W'(SHMAX) : r1.diff;
    wide = {r1.m_sml, 3'b000, {SW{1'b0}}} >> sh;
    // lower half holds every bit shifted past sticky
    aln = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
    xb = {1'b0, r1.m_big, 3'b000};
    xs = {1'b0, aln};
    c2 = '0;
    c2.nan   = r1.nan;
    c2.inf   = r1.inf;
    c2.inf_s = r1.inf_s;
    c2.sign  = r1.s_big;
    // a zero sum is -0 only when both inputs were negative
    c2.zsign = r1.s_big & r1.s_sml;
    c2.e     = r1.e_big;
    c2.sum   = (r1.s_big == r1.s_sml) ? xb + xs : xb - xs;
  end

  // normalise
  logic [LZW-1:0] lz;

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (r2.sum[i]) lz = LZW'(SW - 1 - i);
    end
    c3 = '0;
    c3.nan   = r2.nan;
    c3.inf   = r2.inf;
    c3.inf_s = r2.inf_s;
    c3.zero  = (r2.sum == '0);
    c3.sign  = c3.zero ? r2.zsign : r2.sign;
    if (r2.sum[AW-1]) begin
      c3.m = {r2.sum[AW-1:2], r2.sum[1] | r2.sum[0]};
      c3.e = {{(EW-EXP_W){1'b0}}, r2.e} + EW'(1);
    end else begin
      c3.m = r2.sum[SW-1:0] << lz;
      c3.e = {{(EW-EXP_W){1'b0}}, r2.e}
           - {{(EW-LZW){1'b0}}, lz};
    end
  end

  // round / pack
  logic             g, r, s, up;
  logic [MAN_W+1:0] rm;
  logic [EW-1:0]    ef;
  logic [MAN_W-1:0] fr;
  logic [W-1:0]     o_out;
  logic [2:0]       o_flags;

  always_comb begin
    g  = r3.m[2];
    r  = r3.m[1];
    s  = r3.m[0];
    up = g & (r | s | r3.m[3]);
    rm = {1'b0, r3.m[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    ef = r3.e + {{(EW-1){1'b0}}, rm[MAN_W+1]};
    fr = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
    o_out   = '0;
    o_flags = '0;
    if (r3.nan) begin
      o_out   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      o_flags = 3'b100;
    end else if (r3.inf) begin
      o_out = {r3.inf_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r3.zero) begin
      o_out = {r3.sign, {(W-1){1'b0}}};
    end else if ($signed(r3.e) <= 0) begin
      o_flags = 3'b001;
    end else if ($signed(ef) >= $signed(EMAXW)) begin
      o_out   = {r3.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags = 3'b011;
    end else begin
      o_out   = {r3.sign, ef[EXP_W-1:0], fr};
      o_flags = {2'b00, g | r | s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0            <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      r0            <= '0;
      r1            <= '0;
      r2            <= '0;
      r3            <= '0;
      bus.out_Out   <= '0;
      bus.out_Ready <= 1'b0;
      bus.out_Flags <= '0;
    end else begin
      v0 <= bus.in_En;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      if (bus.in_En) begin
        r0.a   <= bus.in_A;
        r0.b   <= bus.in_B;
        r0.sub <= bus.in_Sub;
      end
      if (v0) r1 <= c1;
      if (v1) r2 <= c2;
      if (v2) r3 <= c3;
      bus.out_Ready <= v3;
      if (v3) begin
        bus.out_Out   <= o_out;
        bus.out_Flags <= o_flags;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: half-precision directed + random vs integer model,
// plus a single-precision build for the wide-format cases.
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) h_if ();
  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) s_if ();

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(h_if.slave)
  );

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(s_if.slave)
  );

  typedef struct packed {
    logic [15:0] r;
    logic [2:0]  f;
  } exp_t;

  // value scaled by 2^24 is an exact integer for every normal half
  function automatic longint h2i(input logic [15:0] v);
    int     e;
    longint m;
    e = int'(v[14:10]);
    if (e == 0) return 0;
    m = longint'({1'b1, v[9:0]}) << (e - 1);
    return v[15] ? -m : m;
  endfunction

  function automatic void ref_half(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] res,
    output logic [2:0]  fl
  );
    logic   sb, neg;
    longint va, vb, sum, mag, q, rem, half;
    int     p, sft, e;
    logic [15:0] bb;
    sb = b[15] ^ sub;
    bb = {sb, b[14:0]};
    va = h2i(a);
    vb = h2i(bb);
    sum = va + vb;
    fl = 3'b000;
    if (sum == 0) begin
      res = {a[15] & sb, 15'h0};
      return;
    end
    neg = (sum < 0);
    mag = neg ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    if (p < 10) begin
      res = 16'h0;
      fl = 3'b001;
      return;
    end
    sft = p - 10;
    q = mag >> sft;
    rem = mag - (q << sft);
    half = (sft > 0) ? (64'sd1 <<< (sft - 1)) : 64'sd0;
    if (sft > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      sft = sft + 1;
    end
    e = sft + 1;
    if (e >= 31) begin
      res = {neg, 5'h1f, 10'h0};
      fl = 3'b011;
    end else begin
      res = {neg, 5'(e), q[9:0]};
      fl = {2'b00, rem != 0};
    end
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    int k;
    k = $urandom_range(0, 9);
    v[15] = 1'($urandom_range(0, 1));
    v[9:0] = 10'($urandom);
    v[14:10] = (k == 0) ? 5'd0 : 5'($urandom_range(14, 29));
    return v;
  endfunction

  task automatic op16(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] res,
    output logic [2:0]  fl,
    output int          lat,
    output int          pulses
  );
    @(negedge clk);
    h_if.in_A = a;
    h_if.in_B = b;
    h_if.in_Sub = sub;
    h_if.in_En = 1'b1;
    @(negedge clk);
    h_if.in_En = 1'b0;
    lat = -1;
    pulses = 0;
    res = '0;
    fl = '0;
    if (h_if.out_Ready) begin
      lat = 0;
      pulses++;
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (h_if.out_Ready) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          res = h_if.out_Out;
          fl = h_if.out_Flags;
        end
      end
    end
  endtask

  task automatic op32(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] res,
    output logic [2:0]  fl,
    output int          lat
  );
    @(negedge clk);
    s_if.in_A = a;
    s_if.in_B = b;
    s_if.in_Sub = sub;
    s_if.in_En = 1'b1;
    @(negedge clk);
    s_if.in_En = 1'b0;
    lat = -1;
    res = '0;
    fl = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (s_if.out_Ready && lat < 0) begin
        lat = i;
        res = s_if.out_Out;
        fl = s_if.out_Flags;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (h_if.out_Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", h_if.out_Ready);
    end
    n_cmp++;
    if (h_if.out_Out !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0000", h_if.out_Out);
    end
    n_cmp++;
    if (h_if.out_Flags !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", h_if.out_Flags);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (h_if.out_Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ready: got %b want 0", h_if.out_Ready);
    end
  endtask

  task automatic test_single;
    logic [15:0] res;
    logic [2:0]  fl;
    int lat, pulses;
    op16(16'h5E40, 16'h6B2F, 1'b0, res, fl, lat, pulses);
    n_cmp++;
    if (lat != 4) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL single_pulses: got %0d want 1", pulses);
    end
    n_cmp++;
    if ({res, fl} !== {16'h6BF7, 3'b000}) begin
      n_bad++;
      $display("FAIL single_value: got %h/%b want 6bf7/000", res, fl);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] want [16];
    int got, first, last;
    for (int i = 0; i < 16; i++) want[i] = (i % 2 == 0) ? 16'h6A67 : 16'h6BF7;
    got = 0;
    first = -1;
    last = -1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          h_if.in_A = 16'h6B2F;
          h_if.in_B = 16'h5E40;
          h_if.in_Sub = (i % 2 == 0);
          h_if.in_En = 1'b1;
        end
        @(negedge clk);
        h_if.in_En = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 16; c++) begin
          @(negedge clk);
          if (h_if.out_Ready) begin
            if (first < 0) first = c;
            last = c;
            n_cmp++;
            if ({h_if.out_Out, h_if.out_Flags} !== {want[got], 3'b000}) begin
              n_bad++;
              $display("FAIL b2b_%0d: got %h/%b want %h/000",
                       got, h_if.out_Out, h_if.out_Flags, want[got]);
            end
            got++;
          end
        end
      end
    join
    n_cmp++;
    if (got != 16 || last - first != 15) begin
      n_bad++;
      $display("FAIL b2b_stream: got %0d results over %0d cycles want 16 over 16",
               got, last - first + 1);
    end
  endtask

  task automatic test_rounding_specials;
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vs [6];
    logic [15:0] wr [6];
    logic [2:0]  wf [6];
    logic [15:0] res;
    logic [2:0]  fl;
    int lat, pulses;
    va = '{16'h3C00, 16'h3C01, 16'h3C00, 16'h7C00, 16'h7BFF, 16'h7E00};
    vb = '{16'h1000, 16'h1000, 16'h3C00, 16'h7C00, 16'h7BFF, 16'h3C00};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    wr = '{16'h3C00, 16'h3C02, 16'h0000, 16'h7E00, 16'h7C00, 16'h7E00};
    wf = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b011, 3'b100};
    for (int i = 0; i < 6; i++) begin
      op16(va[i], vb[i], vs[i], res, fl, lat, pulses);
      n_cmp++;
      if ({res, fl} !== {wr[i], wf[i]} || lat != 4) begin
        n_bad++;
        $display("FAIL directed_%0d: got %h/%b lat %0d want %h/%b lat 4",
                 i, res, fl, lat, wr[i], wf[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] res;
    logic [2:0]  fl;
    int lat, pulses, seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      h_if.in_A = 16'h3C00;
      h_if.in_B = 16'h4000;
      h_if.in_Sub = 1'b0;
      h_if.in_En = 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (h_if.out_Ready !== 1'b0 || h_if.out_Out !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_mid_async: got ready %b out %h want 0/0000",
               h_if.out_Ready, h_if.out_Out);
    end
    @(negedge clk);
    h_if.in_En = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (h_if.out_Ready) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_mid_flush: got %0d pulses want 0", seen);
    end
    op16(16'h3C00, 16'h3C00, 1'b0, res, fl, lat, pulses);
    n_cmp++;
    if ({res, fl} !== {16'h4000, 3'b000} || lat != 4 || pulses != 1) begin
      n_bad++;
      $display("FAIL rst_mid_fresh: got %h/%b lat %0d want 4000/000 lat 4",
               res, fl, lat);
    end
  endtask

  task automatic test_random;
    localparam int NOPS = 300;
    exp_t q [$];
    exp_t e;
    int got, sent;
    logic [15:0] a, b;
    logic        sb;
    logic [15:0] wr;
    logic [2:0]  wf;
    got = 0;
    sent = 0;
    fork
      begin
        while (sent < NOPS) begin
          @(negedge clk);
          if ($urandom_range(0, 3) != 0) begin
            a = rnd_op();
            b = rnd_op();
            if ($urandom_range(0, 3) == 0)
              b = {1'($urandom_range(0, 1)), a[14:10],
                   a[9:0] ^ 10'($urandom_range(0, 15))};
            sb = 1'($urandom_range(0, 1));
            ref_half(a, b, sb, wr, wf);
            q.push_back('{r: wr, f: wf});
            h_if.in_A = a;
            h_if.in_B = b;
            h_if.in_Sub = sb;
            h_if.in_En = 1'b1;
            sent++;
          end else begin
            h_if.in_En = 1'b0;
          end
        end
        @(negedge clk);
        h_if.in_En = 1'b0;
      end
      begin
        for (int c = 0; c < 3000 && got < NOPS; c++) begin
          @(negedge clk);
          if (h_if.out_Ready) begin
            n_cmp++;
            if (q.size() == 0) begin
              n_bad++;
              $display("FAIL rand_spurious: got %h want no result", h_if.out_Out);
            end else begin
              e = q.pop_front();
              if ({h_if.out_Out, h_if.out_Flags} !== {e.r, e.f}) begin
                n_bad++;
                $display("FAIL rand_%0d: got %h/%b want %h/%b",
                         got, h_if.out_Out, h_if.out_Flags, e.r, e.f);
              end
              got++;
            end
          end
        end
      end
    join
    n_cmp++;
    if (got != NOPS) begin
      n_bad++;
      $display("FAIL rand_count: got %0d want %0d", got, NOPS);
    end
  endtask

  task automatic test_single_precision;
    logic [31:0] res;
    logic [2:0]  fl;
    int lat;
    op32(32'h3F800000, 32'h40000000, 1'b0, res, fl, lat);
    n_cmp++;
    if ({res, fl} !== {32'h40400000, 3'b000} || lat != 4) begin
      n_bad++;
      $display("FAIL f32_add: got %h/%b lat %0d want 40400000/000 lat 4",
               res, fl, lat);
    end
    op32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res, fl, lat);
    n_cmp++;
    if ({res, fl} !== {32'h7F800000, 3'b011}) begin
      n_bad++;
      $display("FAIL f32_ovf: got %h/%b want 7f800000/011", res, fl);
    end
  endtask

  initial begin
    h_if.in_A = '0;
    h_if.in_B = '0;
    h_if.in_Sub = 1'b0;
    h_if.in_En = 1'b0;
    s_if.in_A = '0;
    s_if.in_B = '0;
    s_if.in_Sub = 1'b0;
    s_if.in_En = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rounding_specials();
    test_reset_mid();
    test_random();
    test_single_precision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor; the successor to the team's multi-cycle 16-bit half-precision adder. It accepts one operand pair per clock, supports add or subtract per operation, and rounds to nearest-even. It reports invalid, overflow and inexact status. It serves as the shared accumulation primitive for the neuron datapath at any float format selected by parameters.

## Interface
- EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 10, stored fraction width; word width W = 1+EXP_W+MAN_W
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- in_A  in  W  operand A {sign, exponent, fraction}
- in_B  in  W  operand B
- in_Sub  in  1  1: compute A-B; 0: compute A+B
- in_En  in  1  operands valid this cycle; sampled every cycle
- out_Out  out  W  result
- out_Ready  out  1  out_Out and out_Flags valid this cycle (one-cycle pulse per accepted op)
- out_Flags  out  3  {invalid, overflow, inexact}

## Operation
- Effective B sign = B.sign XOR in_Sub; all later stages use the effective sign.
- Subnormal inputs (exp=0) are flushed to signed zero. Results below the minimum normal are flushed to +0 with inexact=1.
- Stage 1 (unpack/swap): prepend hidden 1; swap so |A| >= |B| by {exp,frac} compare; diff = expA-expB.
- Stage 2 (align/add): right-shift the smaller mantissa by min(diff, MAN_W+3); keep guard, round and sticky (OR of all shifted-out bits). Add when signs match, subtract otherwise; the mantissa adder is MAN_W+5 bits wide.
- Stage 3 (normalise): on carry-out, shift right 1 and exp+1, folding the shifted bit into sticky. Otherwise shift left by the leading-zero count and subtract it from exp.
- Stage 4 (round/pack): round to nearest-even on guard/round/sticky. A rounding carry renormalises (exp+1). inexact = guard|round|sticky.
- Overflow: exp >= 2^EXP_W-1 after rounding gives signed Inf with overflow=1 and inexact=1.
- Exact cancellation gives +0. (-0)+(-0) gives -0.
- Specials bypass the datapath but use the same latency:
  - Any NaN input, or Inf-Inf with opposite effective signs, gives canonical NaN {0, all-ones exp, 1 at fraction MSB, 0s} with invalid=1.
  - Otherwise, an Inf input gives that Inf.
- Flags are meaningful only while out_Ready=1. Outside that, they hold their last value.

## Timing
- Fixed latency of 4 cycles: operands sampled on edge N with in_En=1 appear with out_Ready=1 after edge N+4.
- Throughput of 1 op/clk; no backpressure. Back-to-back ops emerge in order, one per cycle.
- A valid bit travels with each stage. Cycles with in_En=0 produce bubbles with out_Ready=0.
- Reset values: out_Out=0, out_Ready=0, out_Flags=0, all stage valid bits 0.
- Reset asserted mid-operation discards every in-flight op; no out_Ready pulse appears for them.
- First acceptance is on the first rising edge after rst deasserts.
- in_Sub is sampled together with in_A and in_B and is carried per op, so mixed add/sub streams are legal.

## Test plan
- Default params, A=0x5E40 (400), B=0x6B2F (3678), in_Sub=0, one-cycle in_En -> out_Out=0x6BF7 (4078), flags=000, out_Ready high exactly 4 cycles later for exactly one cycle.
- Same operands, 16 back-to-back ops alternating in_Sub=1 (B-A ordering via swap, A=0x6B2F, B=0x5E40): subtract ops give 0x6A67 (3278) and add ops give 0x6BF7. Results arrive on 16 consecutive cycles in order.
- Rounding: 0x3C00+0x1000 -> 0x3C00, inexact=1 (tie to even). 0x3C01+0x1000 -> 0x3C02, inexact=1. 0x3C00-0x3C00 -> 0x0000, flags=000.
- Specials and overflow:
  - 0x7C00 with in_Sub=1 and B=0x7C00 -> 0x7E00, invalid=1.
  - 0x7BFF+0x7BFF -> 0x7C00, overflow=1, inexact=1.
  - 0x7E00+0x3C00 -> 0x7E00, invalid=1.
- Reset mid-stream: issue 3 ops, assert rst asynchronously between edges 2 and 3 -> out_Ready stays 0 and out_Out=0 immediately. After release, a fresh op completes with correct latency.
- Parametrised build EXP_W=8, MAN_W=23: 0x3F800000+0x40000000 -> 0x40400000 (1+2=3). 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 with overflow=1.
